// File: rtl/dmem_arbiter_pkg.sv
// Shared types and port-index constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports and memory-side bus of the data-memory arbiter.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              req0, req1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              ack0, ack1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              err1;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output ack0, ack1, rdata0, rdata1, err1, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  ack0, ack1, rdata0, rdata1, err1, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-request round-robin picker: one-hot grant, contention goes to the port
// that did not win last time.
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt
);
   always_comb begin
      o_gnt = i_req;
      if (i_req == 2'b11) o_gnt = i_last ? 2'b01 : 2'b10;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (IDLE -> ACCESS -> RESP), round-robin on contention.
// Define DMEM_ARB_WPROT_EN to block port-1 writes at or above PROT_BASE.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int                ADDR_W    = 8,
   parameter int                DATA_W    = 8,
   parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(8'hF0)
) (
   input logic          clk,
   input logic          rst_n,
   dmem_arbiter_if.slave bus
);

   state_t            r_state, w_next;
   logic              r_last, r_win, r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [1:0]        w_req, w_gnt;
   logic              w_take, w_sel, w_blk;

   // The port just acked still holds req during RESP, so mask it there.
   always_comb begin
      w_req = {bus.req1, bus.req0};
      if (r_state == S_RESP)   w_req[r_win] = 1'b0;
      if (r_state == S_ACCESS) w_req = 2'b00;
   end

   rr_arb2 u_rr (
      .i_req  (w_req),
      .i_last (r_last),
      .o_gnt  (w_gnt)
   );

   assign w_take = |w_gnt;
   assign w_sel  = w_gnt[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:   w_next = w_take ? S_ACCESS : S_IDLE;
         S_ACCESS: w_next = S_RESP;
         S_RESP:   w_next = w_take ? S_ACCESS : S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last  <= PORT_DMA;
         r_win   <= PORT_CPU;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_take) begin
         r_last  <= w_sel;
         r_win   <= w_sel;
         r_we    <= w_sel ? bus.we1    : bus.we0;
         r_addr  <= w_sel ? bus.addr1  : bus.addr0;
         r_wdata <= w_sel ? bus.wdata1 : bus.wdata0;
      end
   end

`ifdef DMEM_ARB_WPROT_EN
   logic r_prot;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_prot <= 1'b0;
      else if (w_take) r_prot <= w_sel & bus.we1 & (bus.addr1 >= PROT_BASE);
   end
   assign w_blk = r_prot;
`else
   assign w_blk = 1'b0;
`endif

   always_comb begin
      bus.mem_addr  = r_addr;
      bus.mem_wdata = r_wdata;
      bus.mem_we    = 1'b0;
      bus.ack0      = 1'b0;
      bus.ack1      = 1'b0;
      bus.rdata0    = '0;
      bus.rdata1    = '0;
      bus.err1      = 1'b0;
      case (r_state)
         S_ACCESS: bus.mem_we = r_we & ~w_blk;
         S_RESP: begin
            if (r_win == PORT_DMA) begin
               bus.ack1   = 1'b1;
               bus.rdata1 = r_we ? '0 : bus.mem_rdata;
               bus.err1   = w_blk;
            end else begin
               bus.ack0   = 1'b1;
               bus.rdata0 = r_we ? '0 : bus.mem_rdata;
            end
         end
         default: ;
      endcase
   end

endmodule
